// File: rtl/count_ones_pkg.sv
// count_ones_pkg: shared sizing helper for the popcount datapath
package count_ones_pkg;
  function automatic int cnt_w(input int dw);
    return $clog2(dw) + 1;
  endfunction
endpackage

// File: rtl/count_ones_if.sv
// count_ones_if: data word in, registered bit count out
interface count_ones_if
  import count_ones_pkg::*;
#(
  parameter int DW = 8
);
  localparam int CW = cnt_w(DW) - 1;
  logic [DW-1:0] data_i;
  logic [CW-1:0] count_o;
  modport master (output data_i, input count_o);
  modport slave (input data_i, output count_o);
endinterface

// File: rtl/count_ones_popcount_tree.sv
// popcount_tree: balanced pairwise adder tree, one bit wider per level
module popcount_tree
  import count_ones_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0]        data_i,
  output logic [cnt_w(DW)-1:0] sum_o
);
  localparam int LV = $clog2(DW);
  for (genvar l = 0; l <= LV; l++) begin : lv
    logic [l:0] s [DW>>l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < DW; i++) begin : g_n
        assign s[i] = data_i[i];
      end
    end else begin : g_add
      for (genvar i = 0; i < (DW >> l); i++) begin : g_n
        assign s[i] = {1'b0, lv[l-1].s[2*i]} + {1'b0, lv[l-1].s[2*i+1]};
      end
    end
  end
  assign sum_o = lv[LV].s[0];
endmodule

// File: rtl/count_ones.sv
// count_ones: registered popcount of a DW-bit word, count truncated to CW bits
module count_ones
  import count_ones_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  count_ones_if.slave bus
);
  localparam int CW = cnt_w(DW) - 1;
  logic [CW:0]   sum;
  logic [CW-1:0] count_d, count_q;
  logic          unused_msb;
  popcount_tree #(.DW(DW)) u_tree (.data_i(bus.data_i), .sum_o(sum));
  // An all-ones word sums to DW, which wraps to zero once the carry is dropped
  assign count_d = sum[CW-1:0];
  assign unused_msb = sum[CW];
  assign bus.count_o = count_q;
  // Output register; reset clears it immediately, independent of the clock
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: tb/tb_count_ones.sv
// tb_count_ones: directed and random checks of count_ones at DW=8 and DW=16
module tb_count_ones;
  logic clk = 0;
  logic rst = 0;
  int pass = 0;
  int total = 0;
  bit armed = 0;
  int m8 = 0;
  int m16 = 0;

  count_ones_if #(.DW(8))  if8 ();
  count_ones_if #(.DW(16)) if16 ();
  count_ones #(.DW(8))  u8  (.clk_i(clk), .rst_i(rst), .bus(if8.slave));
  count_ones #(.DW(16)) u16 (.clk_i(clk), .rst_i(rst), .bus(if16.slave));

  always #5 clk = ~clk;

  // Reference: reset forces 0; each edge out of reset registers popcount mod 2**CW
  always @(posedge clk or posedge rst) begin
    m8 = rst ? 0 : $countones(if8.data_i) % 8;
    m16 = rst ? 0 : $countones(if16.data_i) % 16;
  end

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask

  always @(negedge clk)
    if (armed) begin
      check("cmp8", 32'(if8.count_o), m8);
      check("cmp16", 32'(if16.count_o), m16);
    end

  task automatic apply(input string n, input logic [7:0] d8, input int e8,
                       input logic [15:0] d16, input int e16);
    @(negedge clk);
    #2 if8.data_i = d8;
    if16.data_i = d16;
    @(posedge clk);
    #1 check({n, "_8"}, 32'(if8.count_o), e8);
    check({n, "_16"}, 32'(if16.count_o), e16);
    check({n, "_model8"}, m8, e8);
    check({n, "_model16"}, m16, e16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    if8.data_i = 8'hA5;
    if16.data_i = 16'hA5A5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #3 rst = 1;
    armed = 1;
    #1 check("rst_now_8", 32'(if8.count_o), 0);
    check("rst_now_16", 32'(if16.count_o), 0);
    @(posedge clk);
    #1 check("rst_hold_8", 32'(if8.count_o), 0);
    @(negedge clk);
    #2 rst = 0;
    if8.data_i = 8'h07;
    if16.data_i = 16'h0007;
    #1 check("lat_before_8", 32'(if8.count_o), 0);
    @(posedge clk);
    #1 check("lat_after_8", 32'(if8.count_o), 3);
    check("lat_after_16", 32'(if16.count_o), 3);
    check("lat_model_8", m8, 3);
    apply("b00", 8'h00, 0, 16'h0000, 0);
    apply("b01", 8'h01, 1, 16'h0001, 1);
    apply("b80", 8'h80, 1, 16'h8000, 1);
    apply("b7f", 8'h7F, 7, 16'h7FFF, 15);
    apply("bff", 8'hFF, 0, 16'hFFFF, 0);
    apply("s0f", 8'h0F, 4, 16'h00FF, 8);
    apply("sf0", 8'hF0, 4, 16'hFF00, 8);
    apply("s55", 8'h55, 4, 16'h5555, 8);
    apply("saa", 8'hAA, 4, 16'hAAAA, 8);
    @(negedge clk);
    #2 if8.data_i = 8'h3F;
    if16.data_i = 16'h003F;
    #1 rst = 1;
    #1 check("mid_rst_8", 32'(if8.count_o), 0);
    check("mid_rst_16", 32'(if16.count_o), 0);
    @(posedge clk);
    #1 check("discard_8", 32'(if8.count_o), 0);
    @(negedge clk);
    #2 rst = 0;
    if8.data_i = 8'h03;
    if16.data_i = 16'h0003;
    @(posedge clk);
    #1 check("resume_8", 32'(if8.count_o), 2);
    check("resume_16", 32'(if16.count_o), 2);
    check("resume_model_8", m8, 2);
    repeat (1000) begin
      @(negedge clk);
      #2 if8.data_i = 8'($urandom);
      if16.data_i = 16'($urandom);
    end
    @(negedge clk);
    #1 armed = 0;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
